led_flow_ctrl: RTL and testbench

- Running-light (LED chaser) controller downstream of the clock divider.
- Consumes the free-running 32-bit divider count, selects a speed tap bit, and edge-detects it in the clk200m domain to produce single-cycle step strobes.
- A small state machine advances an N_LED-wide LED pattern in one of four modes, with enable, speed and mode controls driven from board switches.

---
 rtl/led_flow_ctrl_if.sv | 30 +++
 rtl/led_flow_ctrl.sv | 176 +++++++++++++++++
 tb/tb_led_flow_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/led_flow_ctrl_if.sv
// Bundle between the LED chaser and its surroundings: divider count and switch
// controls in, LED pattern and strobes out. Optional PAUSE_BTN_EN adds the pause button.
interface led_flow_ctrl_if #(
  parameter int N_LED = 8
);
  // step is the only qualifier: led and wrap are new in the cycle step=1 and there
  // is no ready, so the consumer must take each step in the cycle it is presented.
  logic [31:0]      clkdiv;
  logic             en;
  logic [1:0]       speed;
  logic [1:0]       mode;
  logic [N_LED-1:0] led;
  logic             step;
  logic             wrap;
  logic [0:0]       dbg_state;
`ifdef PAUSE_BTN_EN
  logic             pause_btn;
  logic             dbg_paused;

  modport master (output clkdiv, en, speed, mode, pause_btn,
                  input  led, step, wrap, dbg_state, dbg_paused);
  modport slave  (input  clkdiv, en, speed, mode, pause_btn,
                  output led, step, wrap, dbg_state, dbg_paused);
`else
  modport master (output clkdiv, en, speed, mode,
                  input  led, step, wrap, dbg_state);
  modport slave  (input  clkdiv, en, speed, mode,
                  output led, step, wrap, dbg_state);
`endif
endinterface

// File: rtl/led_flow_ctrl.sv
// LED chaser: edge-detects a selectable clkdiv tap into step strobes and advances an
// N_LED pattern in one of four modes. Define PAUSE_BTN_EN for the debounced pause button.
module led_flow_ctrl #(
  parameter int N_LED    = 8,
  parameter int TAP_BASE = 22,
  parameter int DB_CNT_W = 20
) (
  input  logic         clk200m,
  input  logic         rst,
  led_flow_ctrl_if.slave bus
);

  localparam logic [0:0] S_LOAD = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [1:0] M_SHL  = 2'b00;
  localparam logic [1:0] M_SHR  = 2'b01;
  localparam logic [1:0] M_PP   = 2'b10;
  localparam logic [1:0] M_FILL = 2'b11;

  logic [0:0]       state;
  logic [1:0]       speed_q;
  logic [1:0]       mode_q;
  logic             tap_d;
  logic             dir;      // 1 = moving toward the MSB (pingpong only)
  logic             paused;
  logic [N_LED-1:0] led_q;
  logic             step_q;
  logic             wrap_q;

  logic [4:0]       tap_idx;
  logic [4:0]       tap_idx_new;
  logic             tap;
  logic             tap_new;
  logic             speed_chg;
  logic             step_int;
  logic [N_LED-1:0] led_nxt;
  logic [N_LED-1:0] led_load;
  logic             wrap_nxt;
  logic             dir_nxt;

  assign tap_idx     = 5'(TAP_BASE) + {3'b000, speed_q};
  assign tap_idx_new = 5'(TAP_BASE) + {3'b000, bus.speed};
  assign tap         = bus.clkdiv[tap_idx];
  assign tap_new     = bus.clkdiv[tap_idx_new];
  assign speed_chg   = (bus.speed != speed_q);

  // A speed change retargets the edge detector, so the old tap_d is meaningless this cycle.
  assign step_int = tap & ~tap_d & bus.en & ~paused & (state == S_RUN) & ~speed_chg;

  always_comb begin
    led_nxt  = led_q;
    wrap_nxt = 1'b0;
    dir_nxt  = dir;
    case (mode_q)
      M_SHL: begin
        led_nxt  = {led_q[N_LED-2:0], led_q[N_LED-1]};
        wrap_nxt = led_q[N_LED-1];
      end
      M_SHR: begin
        led_nxt  = {led_q[0], led_q[N_LED-1:1]};
        wrap_nxt = led_q[0];
      end
      M_PP: begin
        if (dir) begin
          led_nxt = {led_q[N_LED-2:0], 1'b0};
          if (led_nxt[N_LED-1]) dir_nxt = 1'b0;
        end else begin
          led_nxt = {1'b0, led_q[N_LED-1:1]};
          if (led_nxt[0]) begin
            dir_nxt  = 1'b1;
            wrap_nxt = 1'b1;
          end
        end
      end
      default: begin
        if (&led_q) begin
          led_nxt  = '0;
          wrap_nxt = 1'b1;
        end else begin
          led_nxt = {led_q[N_LED-2:0], 1'b1};
        end
      end
    endcase
  end

  always_comb begin
    led_load = '0;
    case (bus.mode)
      M_SHR:   led_load = {1'b1, {(N_LED-1){1'b0}}};
      M_FILL:  led_load = '0;
      default: led_load = {{(N_LED-1){1'b0}}, 1'b1};
    endcase
  end

  always_ff @(posedge clk200m or posedge rst) begin
    if (rst) begin
      state   <= S_LOAD;
      speed_q <= 2'b00;
      mode_q  <= 2'b00;
      tap_d   <= 1'b0;
      dir     <= 1'b1;
      led_q   <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      speed_q <= bus.speed;
      tap_d   <= speed_chg ? tap_new : tap;
      case (state)
        S_LOAD: begin
          led_q  <= led_load;
          dir    <= 1'b1;
          mode_q <= bus.mode;
          state  <= S_RUN;
        end
        S_RUN: begin
          if (bus.mode != mode_q) begin
            mode_q <= bus.mode;
            state  <= S_LOAD;
          end else if (step_int) begin
            led_q  <= led_nxt;
            dir    <= dir_nxt;
            step_q <= 1'b1;
            wrap_q <= wrap_nxt;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

  assign bus.led       = led_q;
  assign bus.step      = step_q;
  assign bus.wrap      = wrap_q;
  assign bus.dbg_state = state;

`ifdef PAUSE_BTN_EN
  logic [1:0]          pb_sync;
  logic                pb_prev;
  logic                pb_level;
  logic                pb_level_d;
  logic [DB_CNT_W-1:0] db_cnt;

  // The level is only accepted after the synchronized input has held still for a full count.
  always_ff @(posedge clk200m or posedge rst) begin
    if (rst) begin
      pb_sync    <= 2'b00;
      pb_prev    <= 1'b0;
      pb_level   <= 1'b0;
      pb_level_d <= 1'b0;
      db_cnt     <= '0;
      paused     <= 1'b0;
    end else begin
      pb_sync    <= {pb_sync[0], bus.pause_btn};
      pb_prev    <= pb_sync[1];
      pb_level_d <= pb_level;
      if (pb_sync[1] != pb_prev) begin
        db_cnt <= '0;
      end else if (~&db_cnt) begin
        db_cnt <= db_cnt + 1'b1;
      end else begin
        pb_level <= pb_prev;
      end
      if (pb_level & ~pb_level_d) paused <= ~paused;
    end
  end

  assign bus.dbg_paused = paused;
`else
  localparam int UNUSED_DB_CNT_W = DB_CNT_W;
  assign paused = 1'b0;
`endif

endmodule

// File: tb/tb_led_flow_ctrl.sv
// Directed bench for led_flow_ctrl: expected (led, wrap) pairs are queued as stimulus
// is issued and a monitor pops one per step strobe.
module tb_led_flow_ctrl;
  localparam int N_LED = 8;
  localparam int W     = N_LED + 1;

  logic        clk200m;
  logic        rst;
  logic [31:0] div_cnt = 32'd0;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_step_cyc = -1;
  int last_gap = 0;

  logic [W-1:0] exp_q[$];

  led_flow_ctrl_if #(.N_LED(N_LED)) bus ();

  led_flow_ctrl #(.N_LED(N_LED), .TAP_BASE(2), .DB_CNT_W(4)) dut (
    .clk200m (clk200m),
    .rst     (rst),
    .bus     (bus.slave)
  );

  // clock / reset block
  initial clk200m = 1'b0;
  always #5 clk200m = ~clk200m;
  always @(posedge clk200m) cyc++;
  always @(negedge clk200m) div_cnt = div_cnt + 32'd1;
  assign bus.clkdiv = div_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic exp(input logic [N_LED-1:0] l, input logic w);
    exp_q.push_back({l, w});
  endtask

  task automatic tick();
    @(negedge clk200m);
    #1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // Two edges after a mode change: one for S_RUN->S_LOAD, one for the load itself.
  task automatic load_check(input string name, input logic [N_LED-1:0] l);
    tick();
    tick();
    check(name, bus.led, l);
  endtask

  // scoreboard monitor
  always @(negedge clk200m) begin
    if (!rst) begin
      if (bus.wrap && !bus.step) check("wrap_without_step", 1, 0);
      if (bus.step) begin
        if (exp_q.size() == 0) begin
          check("unexpected_step", {23'd0, bus.led, bus.wrap}, 32'hffff_ffff);
        end else begin
          check("sb_led_wrap", {23'd0, bus.led, bus.wrap}, {23'd0, exp_q.pop_front()});
        end
        if (last_step_cyc >= 0) begin
          last_gap = cyc - last_step_cyc;
          check("step_gap_gt2", 32'(last_gap > 2), 1);
        end
        last_step_cyc = cyc;
      end
    end
  end

  initial begin
    int n;
    rst       = 1'b1;
    bus.en    = 1'b1;
    bus.speed = 2'd0;
    bus.mode  = 2'd0;
`ifdef PAUSE_BTN_EN
    bus.pause_btn = 1'b0;
`endif
    repeat (3) tick();
    check("rst_led", bus.led, 0);
    check("rst_step", bus.step, 0);
    check("rst_wrap", bus.wrap, 0);
    check("rst_state", bus.dbg_state, 0);

    // SHIFT_L from reset
    exp(8'h02, 0); exp(8'h04, 0); exp(8'h08, 0); exp(8'h10, 0);
    exp(8'h20, 0); exp(8'h40, 0); exp(8'h80, 0); exp(8'h01, 1);
    rst = 1'b0;
    tick();
    check("first_load_shl", bus.led, 8'h01);
    check("state_run", bus.dbg_state, 1);
    wait_drain("drain_shl", 120);

    // PINGPONG: 14-step period, wrap only on landing at bit0
    bus.mode = 2'd2;
    exp(8'h02, 0); exp(8'h04, 0); exp(8'h08, 0); exp(8'h10, 0);
    exp(8'h20, 0); exp(8'h40, 0); exp(8'h80, 0); exp(8'h40, 0);
    exp(8'h20, 0); exp(8'h10, 0); exp(8'h08, 0); exp(8'h04, 0);
    exp(8'h02, 0); exp(8'h01, 1);
    load_check("load_pp", 8'h01);
    wait_drain("drain_pp", 200);

    // FILL: 9-step period
    bus.mode = 2'd3;
    exp(8'h01, 0); exp(8'h03, 0); exp(8'h07, 0); exp(8'h0f, 0);
    exp(8'h1f, 0); exp(8'h3f, 0); exp(8'h7f, 0); exp(8'hff, 0);
    exp(8'h00, 1);
    load_check("load_fill", 8'h00);
    wait_drain("drain_fill", 150);

    // speed 0 -> 3 mid-run
    bus.mode = 2'd0;
    exp(8'h02, 0); exp(8'h04, 0);
    load_check("load_shl2", 8'h01);
    wait_drain("drain_speed0", 60);
    bus.speed = 2'd3;
    exp(8'h08, 0); exp(8'h10, 0); exp(8'h20, 0);
    wait_drain("drain_speed3", 300);
    check("gap_speed3", last_gap, 64);

    // mode switch coincident with a tap edge, then hold with en=0
    bus.speed = 2'd0;
    n = 0;
    do begin
      tick();
      n++;
    end while (div_cnt[2:0] != 3'd4 && n < 20);
    check("tap_align", div_cnt[2:0], 3'd4);
    bus.mode = 2'd1;
    load_check("load_shr", 8'h80);
    bus.en = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (i % 10 == 0) check("en0_frozen", bus.led, 8'h80);
    end
    exp(8'h40, 0); exp(8'h20, 0);
    bus.en = 1'b1;
    wait_drain("drain_reenable", 40);

    // asynchronous reset mid-run
    bus.en = 1'b0;
    rst = 1'b1;
    #1;
    check("async_rst_led", bus.led, 0);
    check("async_rst_step", bus.step, 0);
    tick();
    rst = 1'b0;
    tick();
    check("reload_after_rst", bus.led, 8'h80);

`ifdef PAUSE_BTN_EN
    bus.pause_btn = 1'b1;
    repeat (5) tick();
    bus.pause_btn = 1'b0;
    repeat (30) tick();
    check("glitch_ignored", bus.dbg_paused, 0);
    bus.pause_btn = 1'b1;
    repeat (40) tick();
    bus.pause_btn = 1'b0;
    repeat (30) tick();
    check("press_pauses", bus.dbg_paused, 1);
    bus.en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (i % 10 == 0) check("paused_frozen", bus.led, 8'h80);
    end
    bus.en = 1'b0;
    bus.pause_btn = 1'b1;
    repeat (40) tick();
    bus.pause_btn = 1'b0;
    repeat (30) tick();
    check("press_resumes", bus.dbg_paused, 0);
`endif

    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
